// File: rtl/imem_pkg.sv
// imem_pkg: shared loader state encoding and frame/fetch constants.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: TIMEOUT-cycle down-counter; restart reloads it, expire flags the count reaching zero.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Loaded with TIMEOUT-1 so expire rises on the TIMEOUT-th idle cycle after a restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = W'(TIMEOUT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= W'(TIMEOUT - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: passes CPU fetches to the instruction RAM and loads UART-framed images into it.
// Optional `define LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module imem_boot_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AW        = 8,
    parameter int unsigned TIMEOUT   = 100000,
    parameter logic [7:0]  SYNC_BYTE = imem_pkg::SYNC_BYTE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [30:0]   cpu_addr,
    output logic [31:0]   cpu_data,
    output logic          cpu_stall,
    output logic          cpu_reset_req,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          load_busy,
    output logic          load_err
);

    import imem_pkg::*;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d, waddr_q, waddr_d;
    logic [1:0]    bsel_q, bsel_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d, err_q, err_d;
    logic          busy, is_sync, last_word, fetch_oob, tmo_expire;
    logic [16:0]   n_new;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    xor_q, xor_d;
`endif

    assign busy      = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                       (state_q == DATA)   || (state_q == CHK);
    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign n_new     = {1'b0, cnt_q[15:8], rx_data};
    assign last_word = (32'(cnt_q) == 32'(idx_q) + 32'd1);
    assign fetch_oob = ({1'b0, cpu_addr} >= 32'(DEPTH) * 32'd4);

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(rx_valid || !busy),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        waddr_d = waddr_q;
        bsel_d  = bsel_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            IDLE, ERR: begin
                if (is_sync) begin
                    state_d = CNT_HI;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    bsel_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    cnt_d[15:8] = rx_data;
                    state_d     = CNT_LO;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    cnt_d   = n_new[15:0];
                    state_d = (n_new == '0 || 32'(n_new) > DEPTH) ? ERR : DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    bsel_d  = bsel_q + 2'd1;
                    shift_d = {shift_q[15:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ rx_data;
`endif
                    // Word is registered here and written the following cycle.
                    if (bsel_q == 2'd3) begin
                        wdata_d = {shift_q, rx_data};
                        we_d    = 1'b1;
                        waddr_d = idx_q;
                        idx_d   = idx_q + 1'b1;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    state_d = (rx_data == xor_q) ? DONE : ERR;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (busy && !rx_valid && tmo_expire) begin
            state_d = ERR;
        end
        if (state_d == ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
            bsel_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            bsel_q  <= bsel_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    assign cpu_stall     = (state_q != IDLE);
    assign cpu_reset_req = (state_q == DONE);
    assign load_busy     = busy;
    assign load_err      = err_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_addr      = (state_q == IDLE) ? cpu_addr[AW+1:2] : waddr_q;
    assign cpu_data      = (state_q == IDLE && !fetch_oob) ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed + randomized frame stimulus checked against an expected-image model.
module tb_imem_boot_loader;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [30:0]   cpu_addr;
    logic [31:0]   cpu_data;
    logic          cpu_stall, cpu_reset_req;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          load_busy, load_err;

    logic [31:0]   ram     [DEPTH];
    logic [31:0]   exp_ram [DEPTH];
    logic [31:0]   fw      [DEPTH];
    logic          force_rd;
    logic [31:0]   force_val;
    logic [7:0]    run_xor;
    int unsigned   total = 0, passed = 0;
    int unsigned   we_cnt = 0, rr_cnt = 0;

    imem_boot_loader #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .TIMEOUT  (TIMEOUT),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_stall    (cpu_stall),
        .cpu_reset_req(cpu_reset_req),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .load_busy    (load_busy),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    // External single-port RAM with combinational read.
    assign mem_rdata = force_rd ? force_val : ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        if (cpu_reset_req) rr_cnt <= rr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned idx);
        logic [7:0]    b;
        logic [AW-1:0] a;
        a = idx[AW-1:0];
        for (int k = 3; k >= 0; k--) begin
            b       = w[8*k +: 8];
            run_xor = run_xor ^ b;
            send_byte(b);
            if (k != 0) idle($urandom_range(0, 2));
        end
        check1("wr_we", mem_we, 1'b1);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_data", mem_wdata, w);
        exp_ram[a] = w;
    endtask

    task automatic send_frame(input int unsigned n, input bit bad);
        logic [15:0] n16;
        n16     = 16'(n);
        run_xor = '0;
        send_byte(8'hA5);
        check1("sync_busy", load_busy, 1'b1);
        check1("sync_err_clr", load_err, 1'b0);
        idle($urandom_range(0, 2));
        send_byte(n16[15:8]);
        idle($urandom_range(0, 2));
        send_byte(n16[7:0]);
        for (int unsigned i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            send_word(fw[i[AW-1:0]], i);
        end
`ifdef LOADER_CHECKSUM_EN
        idle($urandom_range(0, 2));
        send_byte(run_xor ^ {7'b0, bad});
`endif
        if (bad) begin
            check1("chk_bad_err", load_err, 1'b1);
            check1("chk_bad_stall", cpu_stall, 1'b1);
            check1("chk_bad_req", cpu_reset_req, 1'b0);
        end else begin
            check1("done_req", cpu_reset_req, 1'b1);
            check1("done_stall", cpu_stall, 1'b1);
            @(negedge clk);
            check1("post_req", cpu_reset_req, 1'b0);
            check1("post_stall", cpu_stall, 1'b0);
            check1("post_busy", load_busy, 1'b0);
        end
    endtask

    task automatic verify_ram(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cpu_addr = 31'(i * 4);
            #1;
            check("ram_word", cpu_data, exp_ram[i[AW-1:0]]);
        end
        cpu_addr = '0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned we_before, rr_before;
        logic [15:0] bad_n;

        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        cpu_addr  = '0;
        force_rd  = 1'b0;
        force_val = '0;
        repeat (2) @(negedge clk);
        check1("rst_stall", cpu_stall, 1'b0);
        check1("rst_req", cpu_reset_req, 1'b0);
        check1("rst_we", mem_we, 1'b0);
        check1("rst_busy", load_busy, 1'b0);
        check1("rst_err", load_err, 1'b0);
        check("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: pass-through fetch and out-of-range NOP
        force_rd  = 1'b1;
        force_val = 32'h3c084000;
        cpu_addr  = 31'h8;
        #1;
        check("fetch_data", cpu_data, 32'h3c084000);
        check("fetch_addr", 32'(mem_addr), 32'd2);
        check1("fetch_stall", cpu_stall, 1'b0);
        cpu_addr = 31'h3C;
        #1;
        check("fetch_last", cpu_data, 32'h3c084000);
        cpu_addr = 31'h40;
        #1;
        check("fetch_oob_edge", cpu_data, 32'h0);
        cpu_addr = 31'h400;
        #1;
        check("fetch_oob", cpu_data, 32'h0);
        force_rd = 1'b0;
        cpu_addr = '0;
        @(negedge clk);

        // T2: two-word directed frame
        fw[0] = 32'h3c084000;
        fw[1] = 32'h8d090020;
        send_frame(2, 1'b0);
        verify_ram(2);

        // Boundary word counts and a random one
        for (int f = 0; f < 3; f++) begin
            n = (f == 0) ? 1 : (f == 1) ? DEPTH : $urandom_range(2, DEPTH - 1);
            for (int unsigned i = 0; i < n; i++) fw[i[AW-1:0]] = $urandom;
            send_frame(n, 1'b0);
            verify_ram(n);
        end

        // Sync byte inside the payload is plain data
        fw[0] = 32'hA5A5A5A5;
        fw[1] = 32'h00A50000;
        send_frame(2, 1'b0);
        verify_ram(2);

        // T3: oversize and zero word counts
        we_before = we_cnt;
        bad_n     = 16'(DEPTH + 1);
        send_byte(8'hA5);
        send_byte(bad_n[15:8]);
        send_byte(bad_n[7:0]);
        check1("big_n_err", load_err, 1'b1);
        check1("big_n_stall", cpu_stall, 1'b1);
        check1("big_n_busy", load_busy, 1'b0);
        send_byte(8'h3C);
        idle(2);
        check1("err_sticky", load_err, 1'b1);
        check("err_nowrite", we_cnt, we_before);
        send_byte(8'hA5);
        check1("resync_err", load_err, 1'b0);
        check1("resync_busy", load_busy, 1'b1);
        send_byte(8'h00);
        send_byte(8'h00);
        check1("zero_n_err", load_err, 1'b1);
        fw[0] = $urandom;
        send_frame(1, 1'b0);
        verify_ram(1);

        // T4: inter-byte timeout
        we_before = we_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h08);
        idle(TIMEOUT - 3);
        check1("tmo_early_busy", load_busy, 1'b1);
        check1("tmo_early_err", load_err, 1'b0);
        idle(6);
        check1("tmo_err", load_err, 1'b1);
        check1("tmo_stall", cpu_stall, 1'b1);
        check1("tmo_busy", load_busy, 1'b0);
        check("tmo_nowrite", we_cnt, we_before);

        // T5: asynchronous reset mid-frame keeps already-written words
        rr_before = rr_cnt;
        fw[0] = $urandom;
        run_xor = '0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(fw[0], 0);
        send_byte(8'h12);
        send_byte(8'h34);
        #2;
        rst_n = 1'b0;
        #1;
        check1("arst_stall", cpu_stall, 1'b0);
        check1("arst_busy", load_busy, 1'b0);
        check1("arst_we", mem_we, 1'b0);
        check1("arst_req", cpu_reset_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check1("arst_idle_stall", cpu_stall, 1'b0);
        check("arst_no_req", rr_cnt, rr_before);
        verify_ram(1);

`ifdef LOADER_CHECKSUM_EN
        // T6: trailing checksum byte
        fw[0] = 32'h11223344;
        send_frame(1, 1'b0);
        verify_ram(1);
        send_frame(1, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
